// File: rtl/clmul_iter_unit_pkg.sv
// Shared types for the iterative carry-less multiply unit.
// Op encodings follow the Zbc CLMUL family.
package clmul_iter_unit_pkg;

    typedef enum logic [1:0] {
        CLMUL  = 2'd0,
        CLMULH = 2'd1,
        CLMULR = 2'd2
    } clmul_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } clmul_state_e;

    localparam int CLMUL_BPC = 4;

endpackage

// File: rtl/clmul_iter_unit_if.sv
// Request/response handshake bundle of the clmul unit.
// Signal names are from the unit's point of view.
interface clmul_iter_unit_if
    import clmul_iter_unit_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int TRANS_ID_BITS = 3
);

    logic                     valid_i;
    logic                     ready_o;
    clmul_op_e                op_i;
    logic [XLEN-1:0]          operand_a_i;
    logic [XLEN-1:0]          operand_b_i;
    logic [TRANS_ID_BITS-1:0] trans_id_i;
    logic                     valid_o;
    logic                     ready_i;
    logic [XLEN-1:0]          result_o;
    logic [TRANS_ID_BITS-1:0] trans_id_o;

    modport master (
        output valid_i, op_i, operand_a_i, operand_b_i, trans_id_i,
        output ready_i,
        input  ready_o, valid_o, result_o, trans_id_o
    );

    modport slave (
        input  valid_i, op_i, operand_a_i, operand_b_i, trans_id_i,
        input  ready_i,
        output ready_o, valid_o, result_o, trans_id_o
    );

endinterface

// File: rtl/clmul_iter_unit_step.sv
// One BUSY iteration: retire BPC bits of the multiplier.
// Purely combinational; the top registers the outputs.
module clmul_iter_unit_step #(
    parameter int XLEN = 64,
    parameter int BPC  = 4
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [2*XLEN-1:0] a_sh_i,
    input  logic [XLEN-1:0]   b_rem_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [2*XLEN-1:0] a_sh_o,
    output logic [XLEN-1:0]   b_rem_o
);

    always_comb begin
        acc_o = acc_i;
        for (int i = 0; i < BPC; i++) begin
            if (b_rem_i[i]) begin
                acc_o = acc_o ^ (a_sh_i << i);
            end
        end
        a_sh_o  = a_sh_i << BPC;
        b_rem_o = b_rem_i >> BPC;
    end

endmodule

// File: rtl/clmul_iter_unit.sv
// Iterative carry-less multiplier (CLMUL/CLMULH/CLMULR).
// Terminates as soon as the remaining multiplier bits are zero.
module clmul_iter_unit
    import clmul_iter_unit_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int BPC           = CLMUL_BPC,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    clmul_iter_unit_if.slave io
);

    clmul_state_e             state_q;
    logic [2*XLEN-1:0]        acc_q;
    logic [2*XLEN-1:0]        a_sh_q;
    logic [XLEN-1:0]          b_rem_q;
    clmul_op_e                op_q;
    logic [TRANS_ID_BITS-1:0] tag_q;
    logic                     valid_q;
    logic [XLEN-1:0]          result_q;
    logic [TRANS_ID_BITS-1:0] tid_out_q;

    logic [2*XLEN-1:0]        acc_n;
    logic [2*XLEN-1:0]        a_sh_n;
    logic [XLEN-1:0]          b_rem_n;
    logic [XLEN-1:0]          res_sel;

    clmul_iter_unit_step #(
        .XLEN (XLEN),
        .BPC  (BPC)
    ) u_step (
        .acc_i   (acc_q),
        .a_sh_i  (a_sh_q),
        .b_rem_i (b_rem_q),
        .acc_o   (acc_n),
        .a_sh_o  (a_sh_n),
        .b_rem_o (b_rem_n)
    );

    // Reserved encoding falls through to the low half.
    always_comb begin
        res_sel = acc_n[XLEN-1:0];
        unique case (1'b1)
            (op_q == CLMULH): res_sel = acc_n[2*XLEN-1:XLEN];
            (op_q == CLMULR): res_sel = acc_n[2*XLEN-2:XLEN-1];
            default:          res_sel = acc_n[XLEN-1:0];
        endcase
    end

    assign io.ready_o    = (state_q == IDLE) & ~flush_i;
    assign io.valid_o    = valid_q;
    assign io.result_o   = result_q;
    assign io.trans_id_o = tid_out_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_sh_q    <= '0;
            b_rem_q   <= '0;
            op_q      <= CLMUL;
            tag_q     <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            tid_out_q <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (io.valid_i) begin
                        acc_q   <= '0;
                        a_sh_q  <= {{XLEN{1'b0}}, io.operand_a_i};
                        b_rem_q <= io.operand_b_i;
                        op_q    <= io.op_i;
                        tag_q   <= io.trans_id_i;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q   <= acc_n;
                    a_sh_q  <= a_sh_n;
                    b_rem_q <= b_rem_n;
                    if (b_rem_n == '0) begin
                        state_q   <= DONE;
                        valid_q   <= 1'b1;
                        result_q  <= res_sel;
                        tid_out_q <= tag_q;
                    end
                end
                DONE: begin
                    if (io.ready_i) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
